// File: rtl/mac_reg_pkg.sv
// Shared definitions for the MAC register-path arbiter and its helpers.
package mac_reg_pkg;
  localparam int MAC_ADDR_W = 8;
  localparam int MAC_DATA_W = 32;
  localparam logic [MAC_DATA_W-1:0] DEFAULT_ABORT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first pending requester after last_i wins.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  pending_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  winner_o,
  output logic [IW-1:0] winner_idx_o,
  output logic          any_valid_o
);
  int idx;

  always_comb begin
    winner_o     = '0;
    winner_idx_o = '0;
    any_valid_o  = 1'b0;
    idx          = 0;
    for (int off = 1; off <= N; off++) begin
      idx = int'(last_i) + off;
      if (idx >= N) idx = idx - N;
      if (!any_valid_o && pending_i[idx]) begin
        winner_o[idx] = 1'b1;
        winner_idx_o  = IW'(idx);
        any_valid_o   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mac_reg_arbiter.sv
// Shares the MAC Avalon-MM register slave between N_REQ masters, one
// transaction at a time, with a watchdog that aborts unacknowledged accesses.
module mac_reg_arbiter
  import mac_reg_pkg::*;
#(
  parameter int                    N_REQ      = 3,
  parameter int                    TIMEOUT    = 255,
  parameter logic [MAC_DATA_W-1:0] ABORT_DATA = DEFAULT_ABORT_DATA
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ*MAC_ADDR_W-1:0]   req_address,
  input  logic [N_REQ-1:0]              req_write,
  input  logic [N_REQ-1:0]              req_read,
  input  logic [N_REQ*MAC_DATA_W-1:0]   req_writedata,
  output logic [N_REQ-1:0]              req_waitrequest,
  output logic [MAC_DATA_W-1:0]         req_readdata,
  output logic [MAC_ADDR_W-1:0]         address,
  output logic                          write,
  output logic                          read,
  output logic [MAC_DATA_W-1:0]         writedata,
  input  logic                          waitrequest,
  input  logic [MAC_DATA_W-1:0]         readdata,
  output logic [N_REQ-1:0]              grant,
  output logic                          timeout_err
);
  localparam int IW = $clog2(N_REQ);

  state_e                  state_q, state_d;
  logic [MAC_ADDR_W-1:0]   addr_q, addr_d;
  logic [MAC_DATA_W-1:0]   wdata_q, wdata_d;
  logic                    wr_q, wr_d;
  logic                    rd_q, rd_d;
  logic [N_REQ-1:0]        grant_q, grant_d;
  logic [IW-1:0]           last_q, last_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [N_REQ-1:0]        rwait_q, rwait_d;
  logic [MAC_DATA_W-1:0]   rdata_q, rdata_d;
  logic                    terr_q, terr_d;

  logic [N_REQ-1:0]        pending;
  logic [N_REQ-1:0]        win;
  logic [IW-1:0]           win_idx;
  logic                    any_valid;
  logic [MAC_ADDR_W-1:0]   sel_addr;
  logic [MAC_DATA_W-1:0]   sel_wdata;
  logic                    sel_wr;
  logic                    sel_rd;
  logic                    mac_ack;
  logic                    abort;

  assign pending = req_write | req_read;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .pending_i    (pending),
    .last_i       (last_q),
    .winner_o     (win),
    .winner_idx_o (win_idx),
    .any_valid_o  (any_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    sel_rd    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        sel_addr  = req_address[MAC_ADDR_W*i +: MAC_ADDR_W];
        sel_wdata = req_writedata[MAC_DATA_W*i +: MAC_DATA_W];
        sel_wr    = req_write[i];
        sel_rd    = req_read[i];
      end
    end
  end

  assign mac_ack = (state_q == BUS) && !waitrequest;
  assign abort   = (state_q == BUS) && waitrequest && (cnt_q == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = BUS;
      BUS:     if (mac_ack || abort) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rwait_d = rwait_q;
    rdata_d = rdata_q;
    terr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          wr_d    = sel_wr;
          // A simultaneous read+write is illegal; the write wins.
          rd_d    = sel_rd & ~sel_wr;
          grant_d = win;
          last_d  = win_idx;
          cnt_d   = '0;
        end
      end
      BUS: begin
        cnt_d = cnt_q + 16'd1;
        if (mac_ack || abort) begin
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          rwait_d = ~grant_q;
          terr_d  = abort;
          if (rd_q) rdata_d = mac_ack ? readdata : ABORT_DATA;
        end
      end
      DONE: begin
        grant_d = '0;
        rwait_d = '1;
        cnt_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      grant_q <= '0;
      last_q  <= IW'(N_REQ - 1);
      cnt_q   <= '0;
      rwait_q <= '1;
      rdata_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rwait_q <= rwait_d;
      rdata_q <= rdata_d;
      terr_q  <= terr_d;
    end
  end

  assign address         = addr_q;
  assign writedata       = wdata_q;
  assign write           = wr_q;
  assign read            = rd_q;
  assign grant           = grant_q;
  assign req_waitrequest = rwait_q;
  assign req_readdata    = rdata_q;
  assign timeout_err     = terr_q;
endmodule

// File: tb/tb_mac_reg_arbiter.sv
// Bench for mac_reg_arbiter: requester queues and a MAC slave model drive the
// DUT; service order and data are predicted from the round-robin rules.
module tb_mac_reg_arbiter;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [23:0]   req_address = '0;
  logic [2:0]    req_write = '0;
  logic [2:0]    req_read = '0;
  logic [95:0]   req_writedata = '0;
  logic [2:0]    req_waitrequest;
  logic [31:0]   req_readdata;
  logic [7:0]    address;
  logic          write;
  logic          read;
  logic [31:0]   writedata;
  logic          waitrequest = 1'b1;
  logic [31:0]   readdata = '0;
  logic [2:0]    grant;
  logic          timeout_err;

  mac_reg_arbiter #(.N_REQ(N), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_address(req_address), .req_write(req_write), .req_read(req_read),
    .req_writedata(req_writedata), .req_waitrequest(req_waitrequest),
    .req_readdata(req_readdata), .address(address), .write(write), .read(read),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] addr; logic [31:0] data; logic wr; logic rd;} txn_t;
  typedef struct packed {logic [3:0] port; logic [7:0] addr; logic wr; logic rd;
                         logic [31:0] wdata; logic [31:0] rdata; logic [31:0] start;} mac_rec_t;
  typedef struct packed {logic [3:0] port; logic [31:0] data;} cpl_t;

  txn_t     reqs [3][16];
  int       head [3];
  int       tail [3];
  mac_rec_t mac_log[$];
  cpl_t     cpl_log[$];

  int          cyc = 0;
  int          strobe_cnt = 0;
  int          cur_wait = 0;
  logic [31:0] cur_rdata = '0;
  bit          stuck = 0;
  bit          rand_wait = 0;
  bit          rand_rdata = 0;
  int          mac_wait = 0;
  logic [31:0] fixed_rdata = '0;
  int          terr_cnt = 0;
  int          model_last = 2;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [3:0] oh2idx(input logic [2:0] g);
    logic [3:0] r;
    r = 4'd15;
    for (int i = 0; i < 3; i++) if (g[i]) r = 4'(i);
    return r;
  endfunction

  function automatic bit any_queued();
    bit r;
    r = 0;
    for (int i = 0; i < 3; i++) if (head[i] != tail[i]) r = 1;
    return r;
  endfunction

  task automatic drive_reqs();
    txn_t t;
    for (int i = 0; i < 3; i++) begin
      if (head[i] != tail[i]) begin
        t = reqs[i][head[i]];
        req_address[8*i +: 8]    = t.addr;
        req_writedata[32*i +: 32] = t.data;
        req_write[i] = t.wr;
        req_read[i]  = t.rd;
      end else begin
        req_write[i] = 1'b0;
        req_read[i]  = 1'b0;
      end
    end
  endtask

  task automatic push(input int p, input logic [7:0] a, input logic [31:0] d,
                      input logic wr, input logic rd);
    txn_t t;
    t.addr = a; t.data = d; t.wr = wr; t.rd = rd;
    reqs[p][tail[p]] = t;
    tail[p]++;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 3; i++) begin head[i] = 0; tail[i] = 0; end
    mac_log.delete();
    cpl_log.delete();
  endtask

  // One clock: observe completions, respond as the MAC, then present requests.
  task automatic tick();
    mac_rec_t m;
    cpl_t c;
    @(posedge clk);
    #1;
    cyc++;
    if (timeout_err) terr_cnt++;
    for (int i = 0; i < 3; i++) begin
      if (!req_waitrequest[i]) begin
        if (head[i] == tail[i]) begin
          n_cmp++; n_err++;
          $display("FAIL spurious_completion port %0d: got waitrequest low, required high (nothing outstanding)", i);
        end else begin
          c.port = 4'(i); c.data = req_readdata;
          cpl_log.push_back(c);
          head[i]++;
        end
      end
    end
    if (write || read) begin
      strobe_cnt++;
      if (strobe_cnt == 1) begin
        cur_wait  = rand_wait ? int'($urandom_range(0, 4)) : mac_wait;
        cur_rdata = rand_rdata ? $urandom : fixed_rdata;
        m.port = oh2idx(grant); m.addr = address; m.wr = write; m.rd = read;
        m.wdata = writedata; m.rdata = cur_rdata; m.start = cyc;
        mac_log.push_back(m);
      end
      waitrequest = stuck || (strobe_cnt <= cur_wait);
      readdata    = cur_rdata;
    end else begin
      strobe_cnt  = 0;
      waitrequest = 1'b1;
    end
    drive_reqs();
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while (any_queued() && n < budget) begin tick(); n++; end
    n_cmp++;
    if (any_queued()) begin
      n_err++;
      $display("FAIL %s_drain: got requests still outstanding after %0d cycles, required all served", name, budget);
      clear_all();
      drive_reqs();
    end
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_all();
    drive_reqs();
    tick(); tick();
    reset = 1'b0;
    model_last = 2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_cmp += 8;
    if (grant !== 3'b000) begin n_err++; $display("FAIL rst_grant: got %b required 000", grant); end
    if (req_waitrequest !== 3'b111) begin n_err++; $display("FAIL rst_rwait: got %b required 111", req_waitrequest); end
    if (write !== 1'b0) begin n_err++; $display("FAIL rst_write: got %b required 0", write); end
    if (read !== 1'b0) begin n_err++; $display("FAIL rst_read: got %b required 0", read); end
    if (address !== 8'h00) begin n_err++; $display("FAIL rst_address: got %h required 00", address); end
    if (writedata !== 32'h0) begin n_err++; $display("FAIL rst_writedata: got %h required 0", writedata); end
    if (req_readdata !== 32'h0) begin n_err++; $display("FAIL rst_readdata: got %h required 0", req_readdata); end
    if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_timeout_err: got %b required 0", timeout_err); end
    reset = 1'b0;
    model_last = 2;
  endtask

  task automatic test_single_write();
    clear_all();
    stuck = 0; rand_wait = 0; mac_wait = 0; rand_rdata = 0; fixed_rdata = 32'h0;
    push(0, 8'h02, 32'h0100_0093, 1'b1, 1'b0);
    drive_reqs();
    tick();
    n_cmp += 5;
    if (write !== 1'b1 || read !== 1'b0) begin n_err++; $display("FAIL sw_strobe: got wr=%b rd=%b required wr=1 rd=0", write, read); end
    if (address !== 8'h02) begin n_err++; $display("FAIL sw_address: got %h required 02", address); end
    if (writedata !== 32'h0100_0093) begin n_err++; $display("FAIL sw_writedata: got %h required 01000093", writedata); end
    if (grant !== 3'b001) begin n_err++; $display("FAIL sw_grant: got %b required 001", grant); end
    if (req_waitrequest !== 3'b111) begin n_err++; $display("FAIL sw_rwait_bus: got %b required 111", req_waitrequest); end
    tick();
    n_cmp += 3;
    if (write !== 1'b0) begin n_err++; $display("FAIL sw_write_drop: got %b required 0", write); end
    if (req_waitrequest !== 3'b110) begin n_err++; $display("FAIL sw_rwait_done: got %b required 110", req_waitrequest); end
    if (grant !== 3'b001) begin n_err++; $display("FAIL sw_grant_done: got %b required 001", grant); end
    tick();
    n_cmp += 2;
    if (req_waitrequest !== 3'b111) begin n_err++; $display("FAIL sw_rwait_idle: got %b required 111", req_waitrequest); end
    if (grant !== 3'b000) begin n_err++; $display("FAIL sw_grant_idle: got %b required 000", grant); end
  endtask

  task automatic test_read_wait();
    bit got;
    clear_all();
    mac_wait = 5; fixed_rdata = 32'h7;
    push(1, 8'h94, 32'h0, 1'b0, 1'b1);
    push(0, 8'($urandom), $urandom, 1'b1, 1'b0);
    push(2, 8'($urandom), $urandom, 1'b1, 1'b0);
    drive_reqs();
    got = 0;
    for (int k = 1; k <= 30 && !got; k++) begin
      tick();
      if (!req_waitrequest[1]) begin
        got = 1;
        n_cmp += 3;
        if (req_readdata !== 32'h7) begin n_err++; $display("FAIL rw_readdata: got %h required 00000007", req_readdata); end
        if (req_waitrequest !== 3'b101) begin n_err++; $display("FAIL rw_others_stalled: got %b required 101", req_waitrequest); end
        if (k != 7) begin n_err++; $display("FAIL rw_latency: got %0d cycles required 7", k); end
      end
    end
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL rw_complete: got no completion in 30 cycles, required one"); end
    mac_wait = 0;
    drain(200, "rw");
    n_cmp++;
    if (mac_log.size() != 3) begin n_err++; $display("FAIL rw_count: got %0d MAC txns required 3", mac_log.size()); end
    else begin
      n_cmp++;
      if (mac_log[0].port != 1 || mac_log[1].port != 2 || mac_log[2].port != 0) begin
        n_err++;
        $display("FAIL rw_order: got %0d,%0d,%0d required 1,2,0", mac_log[0].port, mac_log[1].port, mac_log[2].port);
      end
    end
  endtask

  task automatic test_timeout();
    bit got;
    int rd_hi;
    int terr0;
    clear_all();
    stuck = 1; mac_wait = 0;
    terr0 = terr_cnt;
    push(2, 8'h10, 32'h0, 1'b0, 1'b1);
    push(0, 8'h20, 32'h55, 1'b1, 1'b0);
    drive_reqs();
    got = 0; rd_hi = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      tick();
      if (read) rd_hi++;
      if (!req_waitrequest[2]) begin
        got = 1;
        stuck = 0;
        n_cmp += 3;
        if (req_readdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL to_readdata: got %h required deadbeef", req_readdata); end
        if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_pulse: got %b required 1", timeout_err); end
        if (rd_hi != 16) begin n_err++; $display("FAIL to_strobe_len: got %0d required 16", rd_hi); end
      end
    end
    stuck = 0;
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL to_complete: got no completion in 40 cycles, required one"); end
    tick();
    n_cmp++;
    if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_pulse_width: got %b required 0", timeout_err); end
    drain(100, "to");
    n_cmp += 2;
    if (terr_cnt - terr0 != 1) begin n_err++; $display("FAIL to_pulse_count: got %0d required 1", terr_cnt - terr0); end
    if (mac_log.size() != 2 || mac_log[1].port != 0) begin n_err++; $display("FAIL to_next_served: got %0d txns required port 0 second", mac_log.size()); end
  endtask

  task automatic test_reset_mid_bus();
    clear_all();
    stuck = 1;
    push(1, 8'h30, 32'h1234, 1'b1, 1'b0);
    drive_reqs();
    tick(); tick(); tick(); tick();
    n_cmp++;
    if (write !== 1'b1) begin n_err++; $display("FAIL rb_in_bus: got write=%b required 1", write); end
    reset = 1'b1;
    clear_all();
    drive_reqs();
    tick();
    n_cmp += 3;
    if (write !== 1'b0 || read !== 1'b0) begin n_err++; $display("FAIL rb_strobes: got wr=%b rd=%b required 0 0", write, read); end
    if (grant !== 3'b000) begin n_err++; $display("FAIL rb_grant: got %b required 000", grant); end
    if (req_waitrequest !== 3'b111) begin n_err++; $display("FAIL rb_rwait: got %b required 111", req_waitrequest); end
    reset = 1'b0;
    stuck = 0;
    model_last = 2;
    clear_all();
    push(2, 8'h41, 32'h2, 1'b1, 1'b0);
    push(0, 8'h40, 32'h1, 1'b1, 1'b0);
    drive_reqs();
    drain(100, "rb");
    n_cmp++;
    if (mac_log.size() != 2 || mac_log[0].port != 0) begin n_err++; $display("FAIL rb_first_port: got %0d txns required port 0 first", mac_log.size()); end
  endtask

  task automatic test_rw_illegal();
    bit rd_seen;
    int n;
    clear_all();
    mac_wait = 2;
    push(2, 8'h0E, 32'h4, 1'b1, 1'b1);
    drive_reqs();
    rd_seen = 0; n = 0;
    while (any_queued() && n < 30) begin tick(); n++; if (read) rd_seen = 1; end
    mac_wait = 0;
    drain(10, "ill");
    n_cmp += 2;
    if (rd_seen) begin n_err++; $display("FAIL ill_read: got read=1 required 0"); end
    if (mac_log.size() != 1 || !mac_log[0].wr || mac_log[0].addr != 8'h0E || mac_log[0].wdata != 32'h4) begin
      n_err++; $display("FAIL ill_write: got %0d txns required one write 0E/00000004", mac_log.size());
    end
  endtask

  task automatic test_back_to_back();
    bit w;
    do_reset();
    rand_wait = 0; mac_wait = 0; rand_rdata = 1;
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 4; k++) begin w = 1'($urandom_range(0, 1)); push(p, 8'($urandom), $urandom, w, ~w); end
    drive_reqs();
    drain(200, "b2b");
    n_cmp++;
    if (mac_log.size() != 12 || cpl_log.size() != 12) begin
      n_err++; $display("FAIL b2b_count: got %0d/%0d required 12/12", mac_log.size(), cpl_log.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        n_cmp += 2;
        if (mac_log[k].port != 4'(k % 3)) begin n_err++; $display("FAIL b2b_grant[%0d]: got %0d required %0d", k, mac_log[k].port, k % 3); end
        if (k > 0 && mac_log[k].start - mac_log[k-1].start != 3) begin
          n_err++; $display("FAIL b2b_spacing[%0d]: got %0d required 3", k, mac_log[k].start - mac_log[k-1].start);
        end
        if (mac_log[k].rd) begin
          n_cmp++;
          if (cpl_log[k].data != mac_log[k].rdata) begin n_err++; $display("FAIL b2b_rdata[%0d]: got %h required %h", k, cpl_log[k].data, mac_log[k].rdata); end
        end
      end
    end
  endtask

  task automatic test_random();
    int cnts [3];
    int used [3];
    int exp_order[$];
    int lst, total, p;
    bit moved;
    txn_t t;
    logic wr, rd;
    rand_wait = 1; rand_rdata = 1;
    for (int round = 0; round < 4; round++) begin
      clear_all();
      total = 0;
      for (int i = 0; i < 3; i++) begin
        cnts[i] = int'($urandom_range(0, 6));
        used[i] = 0;
        for (int k = 0; k < cnts[i]; k++) begin
          wr = 1'($urandom_range(0, 1));
          rd = ~wr | ($urandom_range(0, 3) == 0);
          push(i, 8'($urandom), $urandom, wr, rd);
        end
        total += cnts[i];
      end
      exp_order.delete();
      lst = model_last;
      for (int k = 0; k < total; k++) begin
        moved = 0;
        for (int off = 1; off <= 3 && !moved; off++) begin
          p = (lst + off) % 3;
          if (cnts[p] > 0) begin exp_order.push_back(p); cnts[p]--; lst = p; moved = 1; end
        end
      end
      model_last = lst;
      drive_reqs();
      drain(600, "rnd");
      n_cmp++;
      if (mac_log.size() != total || cpl_log.size() != total) begin
        n_err++; $display("FAIL rnd_count: got %0d/%0d required %0d", mac_log.size(), cpl_log.size(), total);
      end else begin
        for (int k = 0; k < total; k++) begin
          p = exp_order[k];
          t = reqs[p][used[p]];
          used[p]++;
          n_cmp += 3;
          if (mac_log[k].port != 4'(p) || cpl_log[k].port != 4'(p)) begin
            n_err++; $display("FAIL rnd_port[%0d]: got mac %0d cpl %0d required %0d", k, mac_log[k].port, cpl_log[k].port, p);
          end
          if (mac_log[k].addr != t.addr || mac_log[k].wr != t.wr || mac_log[k].rd != (t.rd & ~t.wr)) begin
            n_err++; $display("FAIL rnd_cmd[%0d]: got %h wr%b rd%b required %h wr%b rd%b", k,
                              mac_log[k].addr, mac_log[k].wr, mac_log[k].rd, t.addr, t.wr, t.rd & ~t.wr);
          end
          if (t.wr ? (mac_log[k].wdata != t.data) : (cpl_log[k].data != mac_log[k].rdata)) begin
            n_err++; $display("FAIL rnd_data[%0d]: got wdata %h rdata %h required wdata %h rdata %h", k,
                              mac_log[k].wdata, cpl_log[k].data, t.data, mac_log[k].rdata);
          end
        end
      end
    end
    rand_wait = 0; rand_rdata = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin head[i] = 0; tail[i] = 0; end
    test_reset();
    test_single_write();
    test_read_wait();
    test_timeout();
    test_reset_mid_bus();
    test_rw_illegal();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got simulation still running, required finish");
    $fatal(1, "bench time limit");
  end
endmodule
